usb_rx_unstuff: RTL and testbench

- Receive front end of the USB function.
- Takes one sampled D+/D- line pair per sample strobe and performs NRZI decoding, SYNC detection, bit unstuffing and EOP detection.
- Delivers the packet as a serial bit stream plus end-of-packet strobe to the CRC/packet decoder directly downstream (bit_out/bit_avail/done map onto its bitIn/bitInAvail/done).
- Flags stuffing, framing and length errors.

---
 rtl/usb_rx_unstuff.sv | 178 +++++++++++++++++
 tb/tb_usb_rx_unstuff.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_unstuff.sv
// USB receive front end: NRZI decode, SYNC hunt, bit unstuffing and EOP framing.
// Emits unstuffed bits with zero latency alongside done/rx_err strobes for the packet decoder.
module usb_rx_unstuff #(
  parameter int MAX_BITS   = 99,
  parameter int STUFF_RUN  = 6,
  parameter int IDLE_J_RUN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       dp,
  input  logic       dm,
  output logic       bit_out,
  output logic       bit_avail,
  output logic       done,
  output logic       rx_err,
  output logic [6:0] bit_count,
  output logic       busy
);

  localparam int ONES_W = $clog2(STUFF_RUN + 1);
  localparam int JRUN_W = $clog2(IDLE_J_RUN + 1);

  typedef enum logic [2:0] {IDLE, DATA, EOP1, EOP2, ERR} state_t;

  state_t              state_reg, state_next;
  logic                prev_j_reg, prev_j_next;
  logic [ONES_W-1:0]   ones_reg, ones_next;
  logic [7:0]          hist_reg, hist_next;
  logic [3:0]          hist_cnt_reg, hist_cnt_next;
  logic [6:0]          count_reg, count_next;
  logic [JRUN_W-1:0]   jrun_reg, jrun_next;
  logic                se0_seen_reg, se0_seen_next;

  logic line_se0, line_se1, is_j, is_k, d, adv;
  logic emit, done_c, err_c;
  logic [7:0] hist_shift;

  // SE1 shares the SE0 path for EOP purposes; DATA singles it out as a framing error.
  assign line_se0   = (dp == dm);
  assign line_se1   = dp & dm;
  assign is_j       = dp & ~dm;
  assign is_k       = ~dp & dm;
  assign d          = ~(dp ^ prev_j_reg);
  assign adv        = sample_en & ~rst;
  assign hist_shift = {hist_reg[6:0], d};

  always_comb begin
    state_next    = state_reg;
    prev_j_next   = prev_j_reg;
    ones_next     = ones_reg;
    hist_next     = hist_reg;
    hist_cnt_next = hist_cnt_reg;
    count_next    = count_reg;
    jrun_next     = jrun_reg;
    se0_seen_next = se0_seen_reg;
    emit          = 1'b0;
    done_c        = 1'b0;
    err_c         = 1'b0;

    if (adv) begin
      if (!line_se0)
        prev_j_next = dp;
      case (state_reg)
        IDLE: begin
          if (line_se0) begin
            hist_next     = 8'd0;
            hist_cnt_next = 4'd0;
          end else begin
            hist_next     = hist_shift;
            hist_cnt_next = (hist_cnt_reg == 4'd8) ? 4'd8 : hist_cnt_reg + 4'd1;
            // An all-zero history left by reset would otherwise match on the first J.
            if (hist_cnt_reg >= 4'd7 && hist_shift == 8'b0000_0001) begin
              state_next = DATA;
              count_next = 7'd0;
              ones_next  = ONES_W'(1);
            end
          end
        end
        DATA: begin
          if (line_se1) begin
            state_next = ERR;
            err_c      = 1'b1;
          end else if (line_se0) begin
            state_next = EOP1;
          end else if (ones_reg == ONES_W'(STUFF_RUN)) begin
            if (d) begin
              state_next = ERR;
              err_c      = 1'b1;
            end else begin
              ones_next = '0;
            end
          end else if (count_reg == 7'(MAX_BITS)) begin
            state_next = ERR;
            err_c      = 1'b1;
          end else begin
            emit       = 1'b1;
            count_next = count_reg + 7'd1;
            ones_next  = d ? ones_reg + ONES_W'(1) : '0;
          end
        end
        EOP1: begin
          if (line_se0) begin
            state_next = EOP2;
          end else begin
            state_next = ERR;
            err_c      = 1'b1;
          end
        end
        EOP2: begin
          if (is_j) begin
            state_next = IDLE;
            if (count_reg >= 7'd8) done_c = 1'b1;
            else                   err_c  = 1'b1;
          end else begin
            state_next = ERR;
            err_c      = 1'b1;
          end
        end
        ERR: begin
          if (is_j) begin
            se0_seen_next = 1'b0;
            if (se0_seen_reg || jrun_reg == JRUN_W'(IDLE_J_RUN - 1))
              state_next = IDLE;
            else
              jrun_next = jrun_reg + JRUN_W'(1);
          end else if (is_k) begin
            jrun_next     = '0;
            se0_seen_next = 1'b0;
          end else begin
            jrun_next     = '0;
            se0_seen_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase

      if (state_next == ERR && state_reg != ERR) begin
        jrun_next     = '0;
        se0_seen_next = 1'b0;
      end
      if (state_next == IDLE && state_reg != IDLE) begin
        hist_next     = 8'd0;
        hist_cnt_next = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      prev_j_reg   <= 1'b1;
      ones_reg     <= '0;
      hist_reg     <= 8'd0;
      hist_cnt_reg <= 4'd0;
      count_reg    <= 7'd0;
      jrun_reg     <= '0;
      se0_seen_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      prev_j_reg   <= prev_j_next;
      ones_reg     <= ones_next;
      hist_reg     <= hist_next;
      hist_cnt_reg <= hist_cnt_next;
      count_reg    <= count_next;
      jrun_reg     <= jrun_next;
      se0_seen_reg <= se0_seen_next;
    end
  end

  assign bit_avail = emit;
  assign bit_out   = emit & d;
  assign done      = done_c;
  assign rx_err    = err_c;
  assign bit_count = count_reg;
  assign busy      = (state_reg == DATA) || (state_reg == EOP1) || (state_reg == EOP2);

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// Directed bench for usb_rx_unstuff: NRZI-encodes hand-written packets and checks
// strobes, captured bits and counters against hand-computed values.
module tb_usb_rx_unstuff;

  logic       clk = 1'b0;
  logic       rst, sample_en, dp, dm;
  logic       bit_out, bit_avail, done, rx_err, busy;
  logic [6:0] bit_count;

  usb_rx_unstuff dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .dp(dp), .dm(dm),
    .bit_out(bit_out), .bit_avail(bit_avail), .done(done), .rx_err(rx_err),
    .bit_count(bit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int           n_pass, n_total;
  int           n_avail, n_done, n_err, n_bad, n_clash;
  logic [127:0] cap;
  logic [127:0] expv;
  logic         last_done, last_err, cur_j, gaps;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input logic p, input logic m, input logic en);
    dp = p; dm = m; sample_en = en;
    @(negedge clk);
    last_done = done;
    last_err  = rx_err;
    if (bit_avail) begin
      cap[n_avail] = bit_out;
      n_avail++;
    end
    if (done) n_done++;
    if (rx_err) n_err++;
    if (!en && (bit_avail || done || rx_err)) n_bad++;
    if ((done && rx_err) || (bit_avail && (done || rx_err))) n_clash++;
    $display("cyc en=%0b dp=%0b dm=%0b avail=%0b bit=%0b done=%0b err=%0b cnt=%0d busy=%0b",
             en, p, m, bit_avail, bit_out, done, rx_err, bit_count, busy);
    @(posedge clk);
    #1;
  endtask

  task automatic line(input logic p, input logic m);
    if (gaps) cyc(1'b1, 1'b1, 1'b0);
    cyc(p, m, 1'b1);
  endtask

  task automatic send_bit(input logic b);
    if (!b) cur_j = ~cur_j;
    line(cur_j, ~cur_j);
  endtask

  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic idle_j(input int n);
    cur_j = 1'b1;
    for (int i = 0; i < n; i++) line(1'b1, 1'b0);
  endtask

  task automatic sync();
    send_bits(128'h80, 8);
  endtask

  task automatic eop();
    line(1'b0, 1'b0);
    line(1'b0, 1'b0);
    line(1'b1, 1'b0);
    cur_j = 1'b1;
  endtask

  task automatic ack();
    idle_j(4);
    sync();
    send_bits(128'hD2, 8);
    eop();
  endtask

  task automatic clr();
    n_avail = 0; n_done = 0; n_err = 0; n_bad = 0;
    cap = '0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_clash = 0;
    clr();
    rst = 1'b1; sample_en = 1'b0; dp = 1'b1; dm = 1'b0;
    gaps = 1'b0; cur_j = 1'b1; last_done = 1'b0; last_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 128'({bit_out, bit_avail, done, rx_err, busy, bit_count}), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ACK handshake: PID 0xD2 arrives LSB first as 0,1,0,0,1,0,1,1
    clr();
    idle_j(4);
    sync();
    chk("ack_busy_after_sync", 128'(busy), 128'd1);
    send_bits(128'hD2, 8);
    eop();
    chk("ack_done_on_j", 128'(last_done), 128'd1);
    chk("ack_avail", 128'(n_avail), 128'd8);
    chk("ack_bits", cap, 128'hD2);
    chk("ack_done", 128'(n_done), 128'd1);
    chk("ack_err", 128'(n_err), 128'd0);
    chk("ack_count", 128'(bit_count), 128'd8);
    chk("ack_busy_end", 128'(busy), 128'd0);

    // Stuffing: SYNC's trailing 1 plus five data 1s forces the stuffed 0
    clr();
    idle_j(2);
    sync();
    send_bits(128'h05F, 9);
    eop();
    chk("stuff_avail", 128'(n_avail), 128'd8);
    chk("stuff_bits", cap, 128'h3F);
    chk("stuff_done", 128'(n_done), 128'd1);
    chk("stuff_err", 128'(n_err), 128'd0);
    chk("stuff_count", 128'(bit_count), 128'd8);

    // Stuff error, then only 7 J: a following packet must be ignored until SE0-J
    clr();
    idle_j(2);
    sync();
    send_bits(128'h3F, 6);
    chk("stufferr_on_sixth", 128'(last_err), 128'd1);
    chk("stufferr_avail", 128'(n_avail), 128'd5);
    chk("stufferr_busy", 128'(busy), 128'd0);
    chk("stufferr_count_hold", 128'(bit_count), 128'd5);
    idle_j(7);
    sync();
    send_bits(128'hD2, 8);
    eop();
    chk("err7j_ignored_avail", 128'(n_avail), 128'd5);
    chk("err7j_ignored_done", 128'(n_done), 128'd0);
    chk("err7j_single_err", 128'(n_err), 128'd1);
    ack();
    chk("err_se0j_recover_done", 128'(n_done), 128'd1);
    chk("err_se0j_recover_avail", 128'(n_avail), 128'd13);

    // Stuff error then exactly 8 J releases the error state
    clr();
    idle_j(2);
    sync();
    send_bits(128'h3F, 6);
    idle_j(8);
    sync();
    send_bits(128'hD2, 8);
    eop();
    chk("err8j_done", 128'(n_done), 128'd1);
    chk("err8j_err", 128'(n_err), 128'd1);
    chk("err8j_avail", 128'(n_avail), 128'd13);

    // Length: 99 alternating bits pass, the 100th aborts
    clr();
    idle_j(2);
    sync();
    expv = '0;
    for (int i = 0; i < 99; i++) expv[i] = (i % 2 == 1);
    for (int i = 0; i < 99; i++) send_bit(i % 2 == 1);
    chk("len_avail_99", 128'(n_avail), 128'd99);
    chk("len_count_99", 128'(bit_count), 128'd99);
    chk("len_no_err_yet", 128'(n_err), 128'd0);
    chk("len_bits", cap, expv);
    send_bit(1'b1);
    chk("len_err_on_100th", 128'(last_err), 128'd1);
    eop();
    chk("len_avail_final", 128'(n_avail), 128'd99);
    chk("len_count_final", 128'(bit_count), 128'd99);
    chk("len_no_done", 128'(n_done), 128'd0);
    chk("len_err_count", 128'(n_err), 128'd1);

    // Framing: SE0 followed directly by J
    clr();
    idle_j(2);
    sync();
    send_bits(128'h5, 3);
    line(1'b0, 1'b0);
    line(1'b1, 1'b0);
    chk("frame_err_on_j", 128'(last_err), 128'd1);
    chk("frame_avail", 128'(n_avail), 128'd3);
    chk("frame_count", 128'(bit_count), 128'd3);
    chk("frame_no_done", 128'(n_done), 128'd0);
    idle_j(8);

    // Short packet: good EOP but fewer than 8 bits
    clr();
    idle_j(2);
    sync();
    send_bits(128'h6, 4);
    eop();
    chk("short_err_on_j", 128'(last_err), 128'd1);
    chk("short_no_done", 128'(n_done), 128'd0);
    chk("short_count", 128'(bit_count), 128'd4);

    // sample_en low every other cycle with an SE1 on the line
    clr();
    gaps = 1'b1;
    ack();
    gaps = 1'b0;
    chk("gap_avail", 128'(n_avail), 128'd8);
    chk("gap_bits", cap, 128'hD2);
    chk("gap_done", 128'(n_done), 128'd1);
    chk("gap_err", 128'(n_err), 128'd0);
    chk("gap_strobe_while_disabled", 128'(n_bad), 128'd0);

    // Reset in the middle of DATA discards the packet
    clr();
    idle_j(2);
    sync();
    send_bits(128'h2, 3);
    rst = 1'b1;
    send_bit(1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", 128'({bit_out, bit_avail, done, rx_err, busy, bit_count}), 128'd0);
    @(posedge clk);
    #1;
    send_bits(128'hD, 4);
    eop();
    chk("rst_mid_no_done", 128'(n_done), 128'd0);
    chk("rst_mid_no_err", 128'(n_err), 128'd0);
    chk("rst_mid_avail", 128'(n_avail), 128'd3);

    chk("strobe_clash", 128'(n_clash), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
